pru_cmd_scheduler: RTL and testbench
====================================

// Module: pru_cmd_scheduler
// PURPOSE
//  Queues CPU draw commands (rect/circle/bitmap) and sequences them into the PRU draw engine one at a time.
//  Drives PRU start/shape/geometry, holds the fields stable for the whole draw, and runs the start/done handshake.
//  Guards each draw with a watchdog and keeps status for the CPU register block.
//  Sits between the memory-mapped CPU write path and the PRU.
// PARAMETERS
//  DEPTH      8       command FIFO entries; power of two, >=2
//  TIMEOUT    400000  max cycles from pru_start rise to pru_done; fits 19 bits
// PORTS
//  clk            in   1   system clock, same as PRU clk
//  rst_n          in   1   asynchronous active-low reset
//  cmd_valid      in   1   CPU presents a command
//  cmd_ready      out  1   FIFO can accept; equals !full
//  cmd_shape      in   2   00 rect, 01 circle, 1x bitmap
//  cmd_color      in   2   colour index
//  cmd_col        in   10  start/centre column
//  cmd_row        in   9   start/centre row
//  cmd_width      in   10  rectangle width
//  cmd_hr         in   9   height or radius
//  cmd_subtract   in   1   subtract flag
//  flush          in   1   drop all queued (not in-flight) commands
//  err_clr        in   1   clear timeout_err
//  pru_start      out  1   PRU start
//  pru_shape      out  2   to PRU shape_select
//  pru_color      out  2   to PRU color
//  pru_col        out  10  to PRU col
//  pru_row        out  9   to PRU row
//  pru_width      out  10  to PRU width
//  pru_hr         out  9   to PRU height_radius
//  pru_subtract   out  1   to PRU subtract
//  pru_busy       in   1   PRU busy (status only)
//  pru_done       in   1   PRU done
//  queue_level    out  $clog2(DEPTH)+1  entries in FIFO
//  sched_idle     out  1   FSM in S_IDLE and FIFO empty
//  timeout_err    out  1   sticky watchdog flag
//  cmds_done      out  16  count of completed draws; wraps
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1 and sched_idle=1; FIFO empty; FSM in S_IDLE; watchdog 0.
//  FIFO entry: 43 bits {shape,color,col,row,width,hr,subtract}.
//  Push: when cmd_valid && cmd_ready at a rising edge. A push attempted while full is not accepted; nothing is lost.
//  Pop: happens only on the S_IDLE->S_ISSUE transition.
//  Push and pop in the same cycle: level unchanged. cmd_ready does not bypass when full.
//  Pointers are $clog2(DEPTH)+1 bits and wrap naturally. full = (level == DEPTH).
//  flush: empties the FIFO on the next edge and has priority over a same-cycle push. It does not affect the in-flight command.
//  FSM:
//   S_IDLE: if FIFO is non-empty and pru_done==0, pop the head, register it onto the pru_* fields, set pru_start=1, go to S_ISSUE.
//   S_ISSUE: pru_start=1; watchdog increments each cycle.
//    If pru_done==1: pru_start<=0, cmds_done++, go to S_RELEASE.
//    Else if watchdog==TIMEOUT-1: pru_start<=0, timeout_err<=1, go to S_RELEASE (no cmds_done increment).
//   S_RELEASE: pru_start=0; wait for pru_done==0, then go to S_IDLE and clear the watchdog.
//  pru_* fields change only on a pop; they hold their value through S_ISSUE and S_RELEASE.
//  Latency: a command accepted into an empty FIFO at edge N gives pru_start=1 after edge N+1.
//  Back-to-back commands: the next start is issued no earlier than 1 cycle after pru_done falls.
//  err_clr clears timeout_err; if it coincides with a new timeout, the set wins.
//  cmds_done wraps from 0xFFFF to 0.
//  pru_busy is never used for sequencing.
//  Reset asserted mid-draw: pru_start drops immediately and all queued commands are lost.
// TESTING
//  1. Push 1 rect (col=10,row=20,w=5,hr=4) -> pru_start after 2 edges, fields match; done pulse -> start low, cmds_done=1, sched_idle=1.
//  2. Push 9 with DEPTH=8 and a stalled PRU -> 9th held with cmd_ready=0 until first pop; all 9 issued in FIFO order.
//  3. Push and flush in the same cycle with 3 queued -> queue_level=0; in-flight draw completes, cmds_done+1.
//  4. TIMEOUT=16, PRU never asserts done -> start drops at cycle 16, timeout_err=1, next command issues; err_clr -> 0.
//  5. pru_done held high 5 cycles after release -> no new start until done=0, then start on the following edge.
//  6. rst_n low while in S_ISSUE with 4 queued -> pru_start=0, queue_level=0, cmd_ready=1 asynchronously.

Source files
------------

// File: rtl/pru_cmd_scheduler_if.sv
// CPU command bus and PRU draw-engine bus seen by the command scheduler.
// slave = scheduler side; master = the CPU write path / PRU side that drives it.
interface pru_cmd_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_shape;
    logic [1:0] cmd_color;
    logic [9:0] cmd_col;
    logic [8:0] cmd_row;
    logic [9:0] cmd_width;
    logic [8:0] cmd_hr;
    logic       cmd_subtract;

    logic       pru_start;
    logic [1:0] pru_shape;
    logic [1:0] pru_color;
    logic [9:0] pru_col;
    logic [8:0] pru_row;
    logic [9:0] pru_width;
    logic [8:0] pru_hr;
    logic       pru_subtract;
    logic       pru_busy;
    logic       pru_done;

    modport slave (
        input  cmd_valid, cmd_shape, cmd_color, cmd_col, cmd_row, cmd_width, cmd_hr, cmd_subtract,
        output cmd_ready,
        output pru_start, pru_shape, pru_color, pru_col, pru_row, pru_width, pru_hr, pru_subtract,
        input  pru_busy, pru_done
    );

    modport master (
        output cmd_valid, cmd_shape, cmd_color, cmd_col, cmd_row, cmd_width, cmd_hr, cmd_subtract,
        input  cmd_ready,
        input  pru_start, pru_shape, pru_color, pru_col, pru_row, pru_width, pru_hr, pru_subtract,
        output pru_busy, pru_done
    );
endinterface

// File: rtl/pru_cmd_scheduler.sv
// Queues CPU draw commands and issues them to the PRU one at a time with a
// start/done handshake, a per-draw watchdog and status for the register block.
module pru_cmd_scheduler #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 400000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pru_cmd_scheduler_if.slave       bus,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic                     sched_idle,
    output logic                     timeout_err,
    output logic [15:0]              cmds_done
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned EW   = 43;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, level;
    logic            full, empty, push, pop;
    logic [WD_W-1:0] wd;
    logic            wd_hit;
    logic [EW-1:0]   wr_data, head;
    logic [EW-1:0]   fields;
    logic            unused_busy;

    assign unused_busy = bus.pru_busy;

    assign level  = wr_ptr - rd_ptr;
    assign full   = (level == PW'(DEPTH));
    assign empty  = (level == '0);
    assign push   = bus.cmd_valid && !full;
    assign pop    = (state_q == S_IDLE) && !empty && !bus.pru_done;
    assign wd_hit = (wd == WD_W'(TIMEOUT - 1));

    assign wr_data = {bus.cmd_shape, bus.cmd_color, bus.cmd_col, bus.cmd_row,
                      bus.cmd_width, bus.cmd_hr, bus.cmd_subtract};
    assign head    = mem[rd_ptr[AW-1:0]];

    assign bus.cmd_ready = !full;
    assign queue_level   = level;
    assign {bus.pru_shape, bus.pru_color, bus.pru_col, bus.pru_row,
            bus.pru_width, bus.pru_hr, bus.pru_subtract} = fields;

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // flush drops everything still queued; a same-cycle pop has already
    // captured its entry into the in-flight fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pop) state_d = S_ISSUE;
            S_ISSUE:   if (bus.pru_done || wd_hit) state_d = S_RELEASE;
            S_RELEASE: if (!bus.pru_done) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pru_start = (state_q == S_ISSUE);
        sched_idle    = (state_q == S_IDLE) && empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields      <= '0;
            wd          <= '0;
            cmds_done   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop)
                fields <= head;
            if (state_q == S_ISSUE && !bus.pru_done && !wd_hit)
                wd <= wd + 1'b1;
            else if (state_q == S_RELEASE && !bus.pru_done)
                wd <= '0;
            if (state_q == S_ISSUE && bus.pru_done)
                cmds_done <= cmds_done + 1'b1;
            if (state_q == S_ISSUE && !bus.pru_done && wd_hit)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pru_cmd_scheduler.sv
// Directed bench for pru_cmd_scheduler: DEPTH=8, TIMEOUT=16.
module tb_pru_cmd_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, err_clr;
    logic [3:0]  queue_level;
    logic        sched_idle, timeout_err;
    logic [15:0] cmds_done;
    int          n_chk = 0;
    int          n_err = 0;

    pru_cmd_scheduler_if bus();

    pru_cmd_scheduler #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush       (flush),
        .err_clr     (err_clr),
        .queue_level (queue_level),
        .sched_idle  (sched_idle),
        .timeout_err (timeout_err),
        .cmds_done   (cmds_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [9:0] col);
        bus.cmd_valid    = 1'b1;
        bus.cmd_shape    = 2'b01;
        bus.cmd_color    = 2'd2;
        bus.cmd_col      = col;
        bus.cmd_row      = col[8:0] + 9'd1;
        bus.cmd_width    = 10'd7;
        bus.cmd_hr       = 9'd3;
        bus.cmd_subtract = 1'b0;
    endtask

    // Wait (bounded) for a start, check the issued column, then pulse done.
    task automatic serve(input string tag, input logic [9:0] col);
        for (int k = 0; k < 20 && !bus.pru_start; k++) tick();
        chk({tag, "_start"}, bus.pru_start, 1);
        chk({tag, "_col"}, bus.pru_col, col);
        bus.pru_done = 1'b1;
        tick();
        bus.pru_done = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; err_clr = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_shape = '0; bus.cmd_color = '0; bus.cmd_col = '0;
        bus.cmd_row = '0; bus.cmd_width = '0; bus.cmd_hr = '0; bus.cmd_subtract = 1'b0;
        bus.pru_busy = 1'b0; bus.pru_done = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_idle", sched_idle, 1);
        chk("rst_start", bus.pru_start, 0);
        chk("rst_level", queue_level, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_done", cmds_done, 0);
        rst_n = 1'b1;
        tick();

        // single rect
        bus.cmd_valid = 1'b1; bus.cmd_shape = 2'b00; bus.cmd_color = 2'd1;
        bus.cmd_col = 10'd10; bus.cmd_row = 9'd20; bus.cmd_width = 10'd5;
        bus.cmd_hr = 9'd4; bus.cmd_subtract = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        chk("t1_level", queue_level, 1);
        chk("t1_nostart", bus.pru_start, 0);
        tick();
        chk("t1_start", bus.pru_start, 1);
        chk("t1_fields", {bus.pru_shape, bus.pru_color, bus.pru_col, bus.pru_row,
                          bus.pru_width, bus.pru_hr, bus.pru_subtract},
            {2'b00, 2'd1, 10'd10, 9'd20, 10'd5, 9'd4, 1'b0});
        bus.pru_done = 1'b1;
        tick();
        chk("t1_start_low", bus.pru_start, 0);
        chk("t1_cmds", cmds_done, 1);
        chk("t1_hold", bus.pru_col, 10);
        bus.pru_done = 1'b0;
        tick();
        chk("t1_idle", sched_idle, 1);

        // fill with PRU stalled (done high blocks issue), 9th held
        bus.pru_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_cmd(10'(100 + i));
            tick();
        end
        chk("t2_full", queue_level, 8);
        chk("t2_ready", bus.cmd_ready, 0);
        set_cmd(10'd108);
        tick();
        chk("t2_held", queue_level, 8);
        bus.pru_done = 1'b0;
        tick();
        chk("t2_nobypass", queue_level, 7);
        chk("t2_start", bus.pru_start, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t2_ninth", queue_level, 8);
        for (int i = 0; i < 9; i++) serve("t2_ord", 10'(100 + i));
        chk("t2_cmds", cmds_done, 10);

        // flush beats a same-cycle push; in-flight draw survives
        for (int i = 0; i < 4; i++) begin
            set_cmd(10'(200 + i));
            tick();
        end
        chk("t3_level", queue_level, 3);
        set_cmd(10'd204);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("t3_flushed", queue_level, 0);
        chk("t3_inflight", bus.pru_col, 200);
        bus.pru_done = 1'b1;
        tick();
        bus.pru_done = 1'b0;
        chk("t3_cmds", cmds_done, 11);
        tick();
        tick();
        chk("t3_nostart", bus.pru_start, 0);
        chk("t3_idle", sched_idle, 1);

        // watchdog at 16 cycles
        set_cmd(10'd300);
        tick();
        set_cmd(10'd301);
        tick();
        bus.cmd_valid = 1'b0;
        repeat (15) tick();
        chk("t4_still", bus.pru_start, 1);
        chk("t4_noerr", timeout_err, 0);
        tick();
        chk("t4_drop", bus.pru_start, 0);
        chk("t4_err", timeout_err, 1);
        chk("t4_cmds", cmds_done, 11);
        tick();
        tick();
        chk("t4_next", bus.pru_start, 1);
        chk("t4_next_col", bus.pru_col, 301);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_clr", timeout_err, 0);
        serve("t4_b", 10'd301);
        chk("t4_cmds2", cmds_done, 12);

        // done held high after release blocks the next start
        set_cmd(10'd400);
        tick();
        set_cmd(10'd401);
        tick();
        bus.cmd_valid = 1'b0;
        bus.pru_done = 1'b1;
        tick();
        repeat (5) tick();
        chk("t5_blocked", bus.pru_start, 0);
        chk("t5_level", queue_level, 1);
        bus.pru_done = 1'b0;
        tick();
        chk("t5_gap", bus.pru_start, 0);
        tick();
        chk("t5_start", bus.pru_start, 1);
        chk("t5_col", bus.pru_col, 401);
        serve("t5_d", 10'd401);
        chk("t5_cmds", cmds_done, 14);

        // asynchronous reset mid-draw
        for (int i = 0; i < 5; i++) begin
            set_cmd(10'(500 + i));
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("t6_level", queue_level, 4);
        chk("t6_start", bus.pru_start, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_start_low", bus.pru_start, 0);
        chk("t6_level0", queue_level, 0);
        chk("t6_ready", bus.cmd_ready, 1);
        chk("t6_cmds0", cmds_done, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("t6_idle", sched_idle, 1);
        chk("t6_nostart", bus.pru_start, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
